// File: rtl/brc_seq.sv
// Sequential branch comparator.
// Compares two operands CHUNK bits per cycle, most significant chunk first, and stops at the
// first chunk that differs. A signed compare becomes an unsigned one by inverting both sign
// bits when the operands are captured. The captured funct3 then selects the branch outcome.
module brc_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_br_un,
    input  logic [2:0]      i_funct3,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_br_less,
    output logic            o_br_equal,
    output logic            o_br_taken,
    output logic            o_br_illegal
);

    localparam int unsigned NCHUNK = XLEN / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Stop elaboration if the chunk geometry cannot be sliced evenly.
    if ((CHUNK == 0) || ((XLEN % CHUNK) != 0) || ((CHUNK & (CHUNK - 1)) != 0))
    begin : gen_bad_geometry
        $error("brc_seq: CHUNK must be a power of two that divides XLEN");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            less_q, less_d;
    logic            equal_q, equal_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [XLEN-1:0]  sign_bias;
    logic             last_chunk;
    logic             taken_raw;
    logic             illegal_raw;

    // Inverting the MSB maps two's-complement order onto unsigned order.
    assign sign_bias  = {~i_br_un, {(XLEN - 1){1'b0}}};
    assign last_chunk = (k_q == KW'(NCHUNK - 1));

    // Select chunk k of each operand; chunk 0 is the most significant one.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (k_q == KW'(i)) begin
                chunk_a = a_q[(NCHUNK - 1 - i) * CHUNK +: CHUNK];
                chunk_b = b_q[(NCHUNK - 1 - i) * CHUNK +: CHUNK];
            end
        end
    end

    // Next state: capture on accept, walk the chunks, hold the result until it is taken.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        funct3_d = funct3_q;
        less_d   = less_q;
        equal_d  = equal_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    a_d      = i_rs1_data ^ sign_bias;
                    b_d      = i_rs2_data ^ sign_bias;
                    funct3_d = i_funct3;
                    k_d      = '0;
                    less_d   = 1'b0;
                    equal_d  = 1'b0;
                    state_d  = StCmp;
                end
            end
            StCmp: begin
                if (chunk_a != chunk_b) begin
                    // The first differing chunk decides the order outright.
                    less_d  = (chunk_a < chunk_b);
                    equal_d = 1'b0;
                    state_d = StDone;
                end else if (last_chunk) begin
                    less_d  = 1'b0;
                    equal_d = 1'b1;
                    state_d = StDone;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                if (i_ready) begin
                    k_d     = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and captured request; reset discards any transaction in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            funct3_q <= '0;
            less_q   <= 1'b0;
            equal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            funct3_q <= funct3_d;
            less_q   <= less_d;
            equal_q  <= equal_d;
        end
    end

    // Branch decode from the captured funct3; the compare mode was fixed at capture.
    always_comb begin
        taken_raw   = 1'b0;
        illegal_raw = 1'b0;
        case (funct3_q)
            3'b000:         taken_raw = equal_q;
            3'b001:         taken_raw = ~equal_q;
            3'b100, 3'b110: taken_raw = less_q;
            3'b101, 3'b111: taken_raw = ~less_q;
            default:        illegal_raw = 1'b1;
        endcase
    end

    // Handshake flags come straight from the state; result outputs are masked outside DONE.
    always_comb begin
        o_ready      = (state_q == StIdle);
        o_valid      = (state_q == StDone);
        o_br_less    = o_valid & less_q;
        o_br_equal   = o_valid & equal_q;
        o_br_taken   = o_valid & taken_raw;
        o_br_illegal = o_valid & illegal_raw;
    end

endmodule

// File: tb/tb_brc_seq.sv
// Randomised bench for brc_seq against a transaction-level reference model.
module tb_brc_seq;

    localparam int XLEN   = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = XLEN / CHUNK;
    localparam int BOUND  = NCHUNK + 4;

    logic            i_clk      = 1'b0;
    logic            i_rst      = 1'b1;
    logic            i_valid    = 1'b0;
    logic            i_ready    = 1'b0;
    logic            i_br_un    = 1'b0;
    logic [2:0]      i_funct3   = 3'b000;
    logic [XLEN-1:0] i_rs1_data = '0;
    logic [XLEN-1:0] i_rs2_data = '0;
    logic            o_ready;
    logic            o_valid;
    logic            o_br_less;
    logic            o_br_equal;
    logic            o_br_taken;
    logic            o_br_illegal;

    int vectors     = 0;
    int miscompares = 0;

    always #5 i_clk = ~i_clk;

    brc_seq #(
        .XLEN (XLEN),
        .CHUNK(CHUNK)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_rs1_data  (i_rs1_data),
        .i_rs2_data  (i_rs2_data),
        .i_br_un     (i_br_un),
        .i_funct3    (i_funct3),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_br_less   (o_br_less),
        .o_br_equal  (o_br_equal),
        .o_br_taken  (o_br_taken),
        .o_br_illegal(o_br_illegal)
    );

    function automatic void chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: full-width compare, latency from the first differing chunk, funct3 decode.
    function automatic void model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                  input logic un, input logic [2:0] f3,
                                  output logic lt, output logic eq, output logic tk,
                                  output logic il, output int lat);
        logic found;
        found = 1'b0;
        lat   = NCHUNK;
        eq    = (a == b);
        lt    = un ? (a < b) : ($signed(a) < $signed(b));
        for (int i = 0; i < NCHUNK; i++) begin
            if (!found && (a[XLEN-1-i*CHUNK -: CHUNK] != b[XLEN-1-i*CHUNK -: CHUNK])) begin
                found = 1'b1;
                lat   = i + 1;
            end
        end
        il = 1'b0;
        tk = 1'b0;
        case (f3)
            3'b000:         tk = eq;
            3'b001:         tk = !eq;
            3'b100, 3'b110: tk = lt;
            3'b101, 3'b111: tk = !lt;
            default:        il = 1'b1;
        endcase
    endfunction

    // Cycle-level expectation: idle, counting down the latency, or holding a result.
    logic m_done = 1'b0;
    int   m_cnt  = 0;
    logic e_less = 1'b0, e_eq = 1'b0, e_tk = 1'b0, e_il = 1'b0;

    always @(posedge i_clk or posedge i_rst) begin
        int l;
        if (i_rst) begin
            m_done = 1'b0;
            m_cnt  = 0;
        end else if (m_done) begin
            if (i_ready) m_done = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_done = 1'b1;
        end else if (i_valid) begin
            model(i_rs1_data, i_rs2_data, i_br_un, i_funct3, e_less, e_eq, e_tk, e_il, l);
            m_cnt = l;
        end
    end

    // Every cycle, on the falling edge, the DUT must match the model.
    always @(negedge i_clk) begin
        chk("ready",   o_ready,      !m_done && (m_cnt == 0));
        chk("valid",   o_valid,      m_done);
        chk("less",    o_br_less,    m_done & e_less);
        chk("equal",   o_br_equal,   m_done & e_eq);
        chk("taken",   o_br_taken,   m_done & e_tk);
        chk("illegal", o_br_illegal, m_done & e_il);
    end

    // Offer noise that a busy DUT must ignore.
    task automatic jitter(input logic allow_ready);
        i_valid    = 1'($urandom_range(0, 1));
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        i_br_un    = 1'($urandom_range(0, 1));
        i_funct3   = 3'($urandom_range(0, 7));
        i_ready    = allow_ready ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // One request from an idle DUT; called at posedge+1. Returns sampled DUT results.
    task automatic do_req(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic un, input logic [2:0] f3, input int hold,
                          output logic lt, output logic eq, output logic tk,
                          output logic il, output int lat);
        i_rs1_data = a;
        i_rs2_data = b;
        i_br_un    = un;
        i_funct3   = f3;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1;
        lat = 0;
        while (!o_valid && lat < BOUND) begin
            jitter(1'b1);
            @(posedge i_clk);
            #1;
            lat++;
        end
        i_ready = 1'b0;
        if (!o_valid) chk("result_timeout", o_valid, 1'b1);
        lt = o_br_less;
        eq = o_br_equal;
        tk = o_br_taken;
        il = o_br_illegal;
        repeat (hold) begin
            jitter(1'b0);
            @(posedge i_clk);
            #1;
            chk("hold_valid", o_valid, 1'b1);
            chk("hold_ready", o_ready, 1'b0);
            chk("hold_less",  o_br_less, lt);
            chk("hold_equal", o_br_equal, eq);
            chk("hold_taken", o_br_taken, tk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk("post_handshake_ready", o_ready, 1'b1);
    endtask

    // Directed case: pins both the model and the DUT to hand-computed values.
    task automatic directed(input string name, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic un, input logic [2:0] f3,
                            input int hold, input logic x_lt, input logic x_eq,
                            input logic x_tk, input logic x_il, input int x_lat);
        logic lt, eq, tk, il;
        int   lat;
        model(a, b, un, f3, lt, eq, tk, il, lat);
        chk({name, "_model_less"}, lt, x_lt);
        chk_int({name, "_model_lat"}, lat, x_lat);
        do_req(a, b, un, f3, hold, lt, eq, tk, il, lat);
        chk({name, "_less"}, lt, x_lt);
        chk({name, "_equal"}, eq, x_eq);
        chk({name, "_taken"}, tk, x_tk);
        chk({name, "_illegal"}, il, x_il);
        chk_int({name, "_latency"}, lat, x_lat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lt, eq, tk, il, mlt, meq, mtk, mil;
        int   lat, mlat;
        logic [XLEN-1:0] a, b;

        #1;
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_valid", o_valid, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        directed("neg_vs_one",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 0, 1, 0, 1, 0, 1);
        directed("max_vs_one",  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b110, 0, 0, 0, 0, 0, 1);
        directed("equal_beq",   32'h1234_5678, 32'h1234_5678, 1'b0, 3'b000, 0, 0, 1, 1, 0, 4);
        directed("lsb_bgeu",    32'h1234_5678, 32'h1234_5679, 1'b1, 3'b101, 0, 1, 0, 0, 0, 4);
        // Backpressure with a competing request, then a back-to-back accept.
        directed("backpress",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b100, 3, 1, 0, 1, 0, 1);
        directed("back2back",   32'h0000_0005, 32'h0000_0005, 1'b1, 3'b001, 0, 0, 1, 0, 0, 4);

        // Abort a compare partway through with reset.
        i_rs1_data = '0;
        i_rs2_data = '0;
        i_br_un    = 1'b0;
        i_funct3   = 3'b010;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        chk("abort_ready", o_ready, 1'b1);
        chk("abort_valid", o_valid, 1'b0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (8) begin
            @(posedge i_clk);
            #1;
            chk("abort_no_result", o_valid, 1'b0);
        end
        directed("illegal_f3",  32'h0000_0000, 32'h0000_0000, 1'b0, 3'b010, 0, 0, 1, 0, 1, 4);

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (XLEN'($urandom_range(1, 255)) << (CHUNK * $urandom_range(0, NCHUNK - 1)));
                default: b = a ^ (XLEN'(1) << $urandom_range(0, XLEN - 1));
            endcase
            i_br_un  = 1'($urandom_range(0, 1));
            i_funct3 = 3'($urandom_range(0, 7));
            model(a, b, i_br_un, i_funct3, mlt, meq, mtk, mil, mlat);
            do_req(a, b, i_br_un, i_funct3, $urandom_range(0, 3), lt, eq, tk, il, lat);
            chk("rand_less", lt, mlt);
            chk("rand_equal", eq, meq);
            chk("rand_taken", tk, mtk);
            chk("rand_illegal", il, mil);
            chk_int("rand_latency", lat, mlat);
        end

        repeat (2) @(posedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
